// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU and condition function codes,
// status codes and the special register indices.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_e;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;
  localparam logic [3:0] S_BUB = 4'h8;

  localparam logic [3:0] R_RSP  = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;

endpackage

// File: rtl/execute_stage_if.sv
// E pipeline register (driven by decode) and M pipeline register (driven by
// execute) bundled between neighbouring pipeline stages.
interface execute_stage_if #(
  parameter int WIDTH = 64
);
  logic [3:0]       E_stat;
  logic [3:0]       E_icode;
  logic [3:0]       E_ifun;
  logic [WIDTH-1:0] E_valA;
  logic [WIDTH-1:0] E_valB;
  logic [WIDTH-1:0] E_valC;
  logic [3:0]       E_dstE;
  logic [3:0]       E_dstM;

  logic [3:0]       M_stat;
  logic [3:0]       M_icode;
  logic             M_Cnd;
  logic [WIDTH-1:0] M_valE;
  logic [WIDTH-1:0] M_valA;
  logic [3:0]       M_dstE;
  logic [3:0]       M_dstM;

  modport master (
    output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );
endinterface

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: val_e = alu_b op alu_a, plus zero/sign/overflow flags.
module y86_alu
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic signed [WIDTH-1:0] alu_a,
  input  logic signed [WIDTH-1:0] alu_b,
  input  alu_fun_e                fun,
  output logic signed [WIDTH-1:0] val_e,
  output logic                    zf,
  output logic                    sf,
  output logic                    of
);

  logic a_neg, b_neg, r_neg;

  always_comb begin
    val_e = alu_b + alu_a;
    case (fun)
      ALU_SUB: val_e = alu_b - alu_a;
      ALU_AND: val_e = alu_b & alu_a;
      ALU_XOR: val_e = alu_b ^ alu_a;
      default: val_e = alu_b + alu_a;
    endcase
  end

  assign a_neg = alu_a[WIDTH-1];
  assign b_neg = alu_b[WIDTH-1];
  assign r_neg = val_e[WIDTH-1];

  // Signed overflow: add wraps when like-signed operands yield the other sign;
  // sub wraps when the operands differ in sign and the result leaves alu_b's sign.
  always_comb begin
    of = 1'b0;
    case (fun)
      ALU_ADD: of = (a_neg == b_neg) && (r_neg != b_neg);
      ALU_SUB: of = (a_neg != b_neg) && (r_neg != b_neg);
      default: of = 1'b0;
    endcase
  end

  assign zf = (val_e == '0);
  assign sf = r_neg;

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand selection, condition codes, branch/cmov
// condition, e_* forwarding outputs and the M pipeline register.
module execute_stage
  import y86_pkg::*;
#(
  parameter int         WIDTH    = 64,
  parameter logic [3:0] RSP      = R_RSP,
  parameter logic [3:0] RNONE    = R_NONE,
  parameter logic [3:0] STAT_BUB = S_BUB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             M_bubble,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  execute_stage_if.slave   pipe,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_Cnd,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam logic signed [WIDTH-1:0] EIGHT = WIDTH'(8);

  logic signed [WIDTH-1:0] alu_a, alu_b, alu_res;
  alu_fun_e                alu_fun;
  logic                    alu_zf, alu_sf, alu_of;
  logic                    set_cc;

  function automatic logic is_exception(input logic [3:0] stat);
    return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
  endfunction

  function automatic logic cond_eval(input logic [3:0] ifun, input logic zf,
                                     input logic sf, input logic of);
    case (ifun)
      C_YES:   return 1'b1;
      C_LE:    return (sf ^ of) | zf;
      C_L:     return sf ^ of;
      C_E:     return zf;
      C_NE:    return ~zf;
      C_GE:    return ~(sf ^ of);
      C_G:     return ~(sf ^ of) & ~zf;
      default: return 1'b0;
    endcase
  endfunction

  // Instructions that do not use the ALU get zero operands, so valE reads 0.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (pipe.E_icode)
      I_RRMOVQ: alu_a = pipe.E_valA;
      I_IRMOVQ: alu_a = pipe.E_valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = pipe.E_valC;
        alu_b = pipe.E_valB;
      end
      I_OPQ: begin
        alu_a = pipe.E_valA;
        alu_b = pipe.E_valB;
      end
      I_CALL, I_PUSHQ: begin
        alu_a = -EIGHT;
        alu_b = pipe.E_valB;
      end
      I_RET, I_POPQ: begin
        alu_a = EIGHT;
        alu_b = pipe.E_valB;
      end
      default: ;
    endcase
  end

  assign alu_fun = (pipe.E_icode == I_OPQ && pipe.E_ifun <= 4'd3)
                   ? alu_fun_e'(pipe.E_ifun[1:0]) : ALU_ADD;

  y86_alu #(.WIDTH(WIDTH)) u_alu (
    .alu_a (alu_a),
    .alu_b (alu_b),
    .fun   (alu_fun),
    .val_e (alu_res),
    .zf    (alu_zf),
    .sf    (alu_sf),
    .of    (alu_of)
  );

  assign e_valE = alu_res;
  assign e_Cnd  = (pipe.E_icode == I_RRMOVQ || pipe.E_icode == I_JXX)
                  ? cond_eval(pipe.E_ifun, cc_zf, cc_sf, cc_of) : 1'b0;
  assign e_dstE = (pipe.E_icode == I_RRMOVQ && !e_Cnd) ? RNONE : pipe.E_dstE;

  // Flags are frozen while a faulting instruction is further down the pipe.
  assign set_cc = (pipe.E_icode == I_OPQ) && !is_exception(m_stat)
                  && !is_exception(W_stat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (set_cc) begin
      cc_zf <= alu_zf;
      cc_sf <= alu_sf;
      cc_of <= alu_of;
    end
  end

  // ---- E -> M pipeline register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe.M_stat  <= STAT_BUB;
      pipe.M_icode <= I_NOP;
      pipe.M_Cnd   <= 1'b0;
      pipe.M_valE  <= '0;
      pipe.M_valA  <= '0;
      pipe.M_dstE  <= RNONE;
      pipe.M_dstM  <= RNONE;
    end else if (M_bubble) begin
      pipe.M_stat  <= STAT_BUB;
      pipe.M_icode <= I_NOP;
      pipe.M_Cnd   <= 1'b0;
      pipe.M_valE  <= '0;
      pipe.M_valA  <= '0;
      pipe.M_dstE  <= RNONE;
      pipe.M_dstM  <= RNONE;
    end else begin
      pipe.M_stat  <= pipe.E_stat;
      pipe.M_icode <= pipe.E_icode;
      pipe.M_Cnd   <= e_Cnd;
      pipe.M_valE  <= e_valE;
      pipe.M_valA  <= pipe.E_valA;
      pipe.M_dstE  <= e_dstE;
      pipe.M_dstM  <= pipe.E_dstM;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: a vector table for ALU operand/function
// selection plus hand-written sequences for CC, cmov, suppression, bubble, reset.
module tb_execute_stage;
  import y86_pkg::*;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             M_bubble;
  logic [3:0]       m_stat;
  logic [3:0]       W_stat;
  logic [WIDTH-1:0] e_valE;
  logic [3:0]       e_dstE;
  logic             e_Cnd;
  logic             cc_zf, cc_sf, cc_of;

  int n_total = 0;
  int n_pass  = 0;

  execute_stage_if #(.WIDTH(WIDTH)) pipe ();

  execute_stage #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .M_bubble (M_bubble),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .pipe     (pipe.slave),
    .e_valE   (e_valE),
    .e_dstE   (e_dstE),
    .e_Cnd    (e_Cnd),
    .cc_zf    (cc_zf),
    .cc_sf    (cc_sf),
    .cc_of    (cc_of)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [63:0] val_c;
    logic [3:0]  dst_e;
    logic [63:0] exp_val_e;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] va, input logic [63:0] vb,
                       input logic [63:0] vc, input logic [3:0] dst_e);
    pipe.E_stat  = S_AOK;
    pipe.E_icode = icode;
    pipe.E_ifun  = ifun;
    pipe.E_valA  = va;
    pipe.E_valB  = vb;
    pipe.E_valC  = vc;
    pipe.E_dstE  = dst_e;
    pipe.E_dstM  = R_NONE;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cc(input string name, input logic [2:0] exp);
    check(name, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, exp});
  endtask

  initial begin
    vecs[0]  = '{I_IRMOVQ, 4'h0, 64'h0,    64'h0,    64'h1234, 4'h2, 64'h1234};
    vecs[1]  = '{I_RMMOVQ, 4'h0, 64'h0,    64'h20,   64'h10,   4'hF, 64'h30};
    vecs[2]  = '{I_MRMOVQ, 4'h0, 64'h0,    64'h8,    64'hFFFF_FFFF_FFFF_FFF8, 4'hF, 64'h0};
    vecs[3]  = '{I_OPQ,    4'h2, 64'hF0F0, 64'hFF00, 64'h0,    4'h1, 64'hF000};
    vecs[4]  = '{I_OPQ,    4'h3, 64'hF0F0, 64'hFF00, 64'h0,    4'h1, 64'h0FF0};
    vecs[5]  = '{I_OPQ,    4'h5, 64'h2,    64'h3,    64'h0,    4'h1, 64'h5};
    vecs[6]  = '{I_CALL,   4'h0, 64'h0,    64'h200,  64'h0,    4'h4, 64'h1F8};
    vecs[7]  = '{I_RET,    4'h0, 64'h0,    64'h200,  64'h0,    4'h4, 64'h208};
    vecs[8]  = '{I_HALT,   4'h0, 64'h55,   64'h66,   64'h77,   4'hF, 64'h0};
    vecs[9]  = '{I_JXX,    4'h0, 64'h55,   64'h66,   64'h77,   4'hF, 64'h0};
    vecs[10] = '{I_NOP,    4'h0, 64'h55,   64'h66,   64'h77,   4'hF, 64'h0};

    rst_n = 1'b0; M_bubble = 1'b0; m_stat = S_AOK; W_stat = S_AOK;
    drive(I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, R_NONE);
    step(); step();
    check("rst_M_icode", {60'd0, pipe.M_icode}, {60'd0, I_NOP});
    check("rst_M_stat",  {60'd0, pipe.M_stat},  {60'd0, S_BUB});
    check("rst_M_dstE",  {60'd0, pipe.M_dstE},  {60'd0, R_NONE});
    check("rst_M_dstM",  {60'd0, pipe.M_dstM},  {60'd0, R_NONE});
    check("rst_M_valE",  pipe.M_valE, 64'h0);
    check_cc("rst_cc", 3'b100);
    rst_n = 1'b1;

    // Table with a faulting memory-stage stat so CC stays at its reset value
    m_stat = S_ADR;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].icode, vecs[i].ifun, vecs[i].val_a, vecs[i].val_b,
            vecs[i].val_c, vecs[i].dst_e);
      #1;
      check($sformatf("tbl%0d_e_valE", i), e_valE, vecs[i].exp_val_e);
      step();
      check($sformatf("tbl%0d_M_valE", i), pipe.M_valE, vecs[i].exp_val_e);
      check($sformatf("tbl%0d_M_icode", i), {60'd0, pipe.M_icode}, {60'd0, vecs[i].icode});
      check($sformatf("tbl%0d_M_valA", i), pipe.M_valA, vecs[i].val_a);
    end
    check_cc("cc_hold_before_opq", 3'b100);
    m_stat = S_AOK;

    // OPq sub: 3 - 5
    drive(I_OPQ, 4'h1, 64'd5, 64'd3, 64'h0, 4'h2);
    #1;
    check("sub_e_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    check_cc("sub_cc", 3'b010);
    check("sub_M_valE", pipe.M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_M_dstE", {60'd0, pipe.M_dstE}, 64'h2);

    // OPq add overflow
    drive(I_OPQ, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h2);
    #1;
    check("addov_e_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    check_cc("addov_cc", 3'b011);

    // cmovle with CC all clear, then with ZF set
    drive(I_OPQ, 4'h0, 64'd1, 64'd1, 64'h0, 4'h2);
    step();
    check_cc("add_small_cc", 3'b000);
    drive(I_RRMOVQ, 4'h1, 64'hAB, 64'h0, 64'h0, 4'h3);
    #1;
    check("cmovle_nt_Cnd",  {63'd0, e_Cnd}, 64'h0);
    check("cmovle_nt_dstE", {60'd0, e_dstE}, {60'd0, R_NONE});
    step();
    check("cmovle_nt_M_dstE", {60'd0, pipe.M_dstE}, {60'd0, R_NONE});
    drive(I_OPQ, 4'h3, 64'd5, 64'd5, 64'h0, 4'h2);
    step();
    check_cc("xor_zero_cc", 3'b100);
    drive(I_RRMOVQ, 4'h1, 64'hAB, 64'h0, 64'h0, 4'h3);
    #1;
    check("cmovle_t_Cnd",  {63'd0, e_Cnd}, 64'h1);
    check("cmovle_t_dstE", {60'd0, e_dstE}, 64'h3);
    check("cmovle_t_valE", e_valE, 64'hAB);
    step();
    check("cmovle_t_M_Cnd", {63'd0, pipe.M_Cnd}, 64'h1);

    // Other conditions against CC = Z only
    drive(I_JXX, 4'h4, 64'h0, 64'h0, 64'h0, R_NONE); #1;
    check("jne_Cnd", {63'd0, e_Cnd}, 64'h0);
    drive(I_JXX, 4'h3, 64'h0, 64'h0, 64'h0, R_NONE); #1;
    check("je_Cnd", {63'd0, e_Cnd}, 64'h1);
    drive(I_JXX, 4'h7, 64'h0, 64'h0, 64'h0, R_NONE); #1;
    check("jbad_Cnd", {63'd0, e_Cnd}, 64'h0);
    drive(I_RMMOVQ, 4'h3, 64'h0, 64'h0, 64'h0, R_NONE); #1;
    check("noncond_Cnd", {63'd0, e_Cnd}, 64'h0);
    step();

    // Exception suppression
    drive(I_OPQ, 4'h1, 64'd5, 64'd3, 64'h0, 4'h2);
    m_stat = S_ADR;
    step();
    check_cc("supp_m_cc", 3'b100);
    m_stat = S_AOK; W_stat = S_INS;
    step();
    check_cc("supp_w_cc", 3'b100);
    W_stat = S_AOK;
    step();
    check_cc("unsupp_cc", 3'b010);

    // Stack adjust, then bubble
    drive(I_PUSHQ, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4); #1;
    check("push_e_valE", e_valE, 64'hF8);
    step();
    check("push_M_valE", pipe.M_valE, 64'hF8);
    drive(I_POPQ, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4); #1;
    check("pop_e_valE", e_valE, 64'h108);
    M_bubble = 1'b1;
    step();
    check("bub_M_icode", {60'd0, pipe.M_icode}, {60'd0, I_NOP});
    check("bub_M_dstE",  {60'd0, pipe.M_dstE},  {60'd0, R_NONE});
    check("bub_M_stat",  {60'd0, pipe.M_stat},  {60'd0, S_BUB});
    check("bub_M_valE",  pipe.M_valE, 64'h0);
    drive(I_OPQ, 4'h0, 64'h0, 64'h0, 64'h0, 4'h2);
    step();
    check_cc("bub_cc_update", 3'b100);
    M_bubble = 1'b0;

    // Asynchronous reset mid-cycle discards the in-flight result
    drive(I_OPQ, 4'h1, 64'd5, 64'd3, 64'h0, 4'h2);
    step();
    check("pre_rst_M_icode", {60'd0, pipe.M_icode}, {60'd0, I_OPQ});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_M_icode", {60'd0, pipe.M_icode}, {60'd0, I_NOP});
    check("async_M_stat",  {60'd0, pipe.M_stat},  {60'd0, S_BUB});
    check("async_M_dstE",  {60'd0, pipe.M_dstE},  {60'd0, R_NONE});
    check_cc("async_cc", 3'b100);
    step();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 pipeline execute stage. It sits directly downstream of the decode stage and consumes the E_* pipeline register that decode drives.
- Contains the ALU, the condition-code register (ZF/SF/OF) and the branch/cmov condition evaluation.
- Produces e_* forwarding signals for decode, and owns the M_* pipeline register consumed by the memory stage.

Parameters:
- WIDTH, 64, data path width in bits.
- RSP, 4'h4, stack pointer register index.
- RNONE, 4'hF, "no register" index.
- STAT_BUB, 4'h8, stat value loaded on bubble/reset.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- M_bubble  in  1  load bubble into M register this edge.
- E_stat  in  4  stat from E register.
- E_icode  in  4  instruction code.
- E_ifun  in  4  function code.
- E_valA  in  WIDTH  operand A.
- E_valB  in  WIDTH  operand B.
- E_valC  in  WIDTH  constant.
- E_dstE  in  4  ALU destination register.
- E_dstM  in  4  memory destination register.
- m_stat  in  4  stat of the instruction currently in memory stage.
- W_stat  in  4  stat of the instruction currently in writeback.
- e_valE  out  WIDTH  ALU result (combinational, forwarding).
- e_dstE  out  4  effective dstE (combinational, forwarding).
- e_Cnd  out  1  condition result (combinational, to hazard unit).
- M_stat, M_icode  out  4 each  M register fields.
- M_Cnd  out  1  registered condition.
- M_valE  out  WIDTH  registered ALU result.
- M_valA  out  WIDTH  registered valA.
- M_dstE, M_dstM  out  4 each  registered destinations.
- cc_zf, cc_sf, cc_of  out  1 each  condition-code register (debug/observation).

Behaviour:
- Reset (async, rst_n=0):
  - CC = {ZF=1, SF=0, OF=0}.
  - M_icode = 4'h1 (nop), M_stat = STAT_BUB, M_Cnd = 0, M_valE = M_valA = 0, M_dstE = M_dstM = RNONE.
  - Reset mid-operation discards any in-flight result immediately.
- ALU operands (aluA, aluB) by icode; valE = aluB op aluA:
  - cmovXX 2: aluA = valA, aluB = 0.
  - irmovq 3: aluA = valC, aluB = 0.
  - rmmovq 4 / mrmovq 5: aluA = valC, aluB = valB.
  - OPq 6: aluA = valA, aluB = valB.
  - call 8 / pushq A: aluA = -8, aluB = valB.
  - ret 9 / popq B: aluA = +8, aluB = valB.
  - all others (including 0, 1, 7): valE = 0.
- ALU function:
  - OPq uses ifun: 0 add, 1 sub (valB-valA), 2 and, 3 xor.
  - ifun > 3 with OPq behaves as add.
  - All other icodes add.
  - Arithmetic is WIDTH-bit modular; carry out is discarded.
- Flags computed from an OPq result:
  - ZF = (valE==0).
  - SF = valE[MSB].
  - OF, add: operands same sign and result sign differs.
  - OF, sub: valA, valB differ in sign and result sign differs from valB.
  - OF is 0 for and/xor.
- set_cc = (E_icode==6) && m_stat∉{2,3,4} && W_stat∉{2,3,4}. CC updates on the posedge only when set_cc=1; otherwise it holds. M_bubble does not block CC update.
- Condition e_Cnd is evaluated from the current (pre-update) CC:
  - ifun 0 always 1.
  - ifun 1 le: (SF^OF)|ZF.
  - ifun 2 l: SF^OF.
  - ifun 3 e: ZF.
  - ifun 4 ne: ~ZF.
  - ifun 5 ge: ~(SF^OF).
  - ifun 6 g: ~(SF^OF)&~ZF.
  - ifun >6: 0.
  - For icodes other than 2 and 7, e_Cnd = 0.
- e_dstE = (E_icode==2 && !e_Cnd) ? RNONE : E_dstE.
- M register update on posedge:
  - M_bubble=1: load the reset values (except CC, which follows the set_cc rule).
  - Otherwise: M_stat = E_stat, M_icode = E_icode, M_Cnd = e_Cnd, M_valE = e_valE, M_valA = E_valA, M_dstE = e_dstE, M_dstM = E_dstM.
- Latency: one cycle from E register to M register; e_* outputs are zero-latency.
- There is no stall input. The M register always advances or bubbles.

Decomposition:
- Package y86_pkg holds:
  - icode constants (HALT..POPQ).
  - ALU function codes.
  - condition function codes.
  - stat codes (AOK=1, HLT=2, ADR=3, INS=4, BUB=8).
  - RSP and RNONE.
- One sub-module, y86_alu: combinational; takes aluA, aluB, fun; returns valE, zf, sf, of.
- CC register, condition logic and M register stay in execute_stage.

Test Plan:
- Reset: rst_n low mid-cycle -> M_icode=1, M_dstE=F, M_stat=8, CC=100 asynchronously; CC holds until the first OPq.
- OPq sub: valA=5, valB=3 -> e_valE=0xFFFF_FFFF_FFFF_FFFE; next edge ZF=0, SF=1, OF=0, M_valE as computed.
- OPq add overflow: valA=valB=0x7FFF_FFFF_FFFF_FFFF -> e_valE=0xFFFF_FFFF_FFFF_FFFE, OF=1, SF=1, ZF=0.
- cmovle: CC ZF=0, SF=0, OF=0, E_dstE=3 -> e_Cnd=0, e_dstE=F; then CC ZF=1 -> e_Cnd=1, e_dstE=3, e_valE=valA.
- Exception suppression: OPq with m_stat=3 -> CC unchanged; same OPq with m_stat=1 and W_stat=1 -> CC updated.
- Stack/bubble: pushq valB=0x100 -> e_valE=0xF8; popq valB=0x100 -> e_valE=0x108. With M_bubble=1, the M register loads nop, dst F, stat 8 instead.
